// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS ALU and its two-requester arbiter.
//   - ALU_* : 4-bit ALU control codes understood by mips_alu
//   - state_t : arbiter FSM state encoding (2 bits)
//   - alu_op_t : one captured ALU operation (requester id, ctrl, operands)
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        id;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
   } alu_op_t;

endpackage

// File: rtl/mips_alu.sv
// ---------------------------------------------------------------------------
// mips_alu
//   Purely combinational 32-bit MIPS ALU.
//   Ports:
//     ctrl   in  4   operation code (mips_pkg::ALU_*)
//     a      in  32  operand in1
//     b      in  32  operand in2
//     result out 32  operation result (0 for unsupported codes)
//     zero   out 1   result == 0
//     cout   out 1   carry out of the 33-bit ADD; 0 for every other code
// ---------------------------------------------------------------------------
module mips_alu
   import mips_pkg::*;
(
   input  logic [3:0]  ctrl,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        zero,
   output logic        cout
);

   logic [32:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case can leave it unassigned and infer a latch.
      result = '0;
      cout   = 1'b0;
      case (ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: begin
            result = sum[31:0];
            cout   = sum[32];
         end
         ALU_SUB: result = a - b;
         ALU_SLT: result = (a < b) ? 32'd1 : 32'd0;
         ALU_NOR: result = ~(a | b);
         default: result = '0;
      endcase
   end

   assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_alu_arbiter.sv
// ---------------------------------------------------------------------------
// mips_alu_arbiter
//   Shares one mips_alu between requester 0 (EX stage) and requester 1
//   (branch/address helper). An accepted operation is captured into operand
//   registers, evaluated during EXEC and held in registered rsp_* outputs
//   until the consumer takes it. Handshake in cycle 0, rsp_valid in cycle 2.
//   Parameter:
//     FIXED_PRI  0 = round-robin on a tie, 1 = requester 0 always wins a tie
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     req0_valid/ready/ctrl/a/b   requester 0 request (ready is combinational)
//     req1_valid/ready/ctrl/a/b   requester 1 request (ready is combinational)
//     rsp_valid/rsp_ready         response handshake
//     rsp_id                      requester that issued the response
//     rsp_data/zero/cout          ALU result, result==0, ADD carry out
//     rsp_illegal                 captured ctrl was not a supported code
// ---------------------------------------------------------------------------
module mips_alu_arbiter
   import mips_pkg::*;
#(
   parameter bit FIXED_PRI = 1'b0
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_ctrl,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_ctrl,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_zero,
   output logic        rsp_cout,
   output logic        rsp_illegal
);

   state_t      state_q, state_d;
   logic        last_grant_q;
   alu_op_t     op_q;

   logic        grant0, grant1;
   logic        can_accept;
   logic        handshake;
   logic        load_rsp, drop_rsp;

   logic [31:0] alu_result;
   logic        alu_zero, alu_cout;
   logic        op_illegal;

   // ---------------- arbitration ----------------
   // On a tie the round-robin pointer favours the requester that did not
   // win last; last_grant resets to 1 so requester 0 wins the first tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         if (FIXED_PRI || last_grant_q) grant0 = 1'b1;
         else                           grant1 = 1'b1;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   // A held response frees the slot in the same cycle it is consumed, which
   // lets a new operation start while the previous one is being taken.
   assign can_accept = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
   assign req0_ready = can_accept && grant0;
   assign req1_ready = can_accept && grant1;
   assign handshake  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (handshake) last_grant_q <= grant1;
      end
   end

   always_comb begin
      state_d  = state_q;
      load_rsp = 1'b0;
      drop_rsp = 1'b0;
      case (state_q)
         ST_IDLE: if (handshake) state_d = ST_EXEC;
         ST_EXEC: begin
            load_rsp = 1'b1;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               drop_rsp = 1'b1;
               state_d  = handshake ? ST_EXEC : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- operand capture ----------------
   // NOTE: operand registers are pure datapath and carry no reset; a reset
   // returns the FSM to IDLE, so whatever they hold is never consumed.
   always_ff @(posedge clk) begin
      if (handshake) begin
         op_q.id   <= grant1;
         op_q.ctrl <= grant1 ? req1_ctrl : req0_ctrl;
         op_q.a    <= grant1 ? req1_a    : req0_a;
         op_q.b    <= grant1 ? req1_b    : req0_b;
      end
   end

   mips_alu u_alu (
      .ctrl   (op_q.ctrl),
      .a      (op_q.a),
      .b      (op_q.b),
      .result (alu_result),
      .zero   (alu_zero),
      .cout   (alu_cout)
   );

   always_comb begin
      case (op_q.ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: op_illegal = 1'b0;
         default:                                             op_illegal = 1'b1;
      endcase
   end

   // ---------------- response registers ----------------
   // rsp_* only change when a new result is loaded; dropping rsp_valid after
   // consumption leaves the payload as it was.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_data    <= '0;
         rsp_zero    <= 1'b0;
         rsp_cout    <= 1'b0;
         rsp_illegal <= 1'b0;
      end else if (load_rsp) begin
         rsp_valid   <= 1'b1;
         rsp_id      <= op_q.id;
         rsp_data    <= alu_result;
         rsp_zero    <= alu_zero;
         rsp_cout    <= alu_cout;
         rsp_illegal <= op_illegal;
      end else if (drop_rsp) begin
         rsp_valid   <= 1'b0;
      end
   end

endmodule
